// File: rtl/audio_dma_arbiter_pkg.sv
// Shared state encoding and limits for the audio DMA arbiter.
package AUDIO_pkg;

    localparam int unsigned AUDIO_ARB_MAX_CH = 8;

    typedef enum logic [1:0] {
        AS_IDLE = 2'd0,
        AS_BUS  = 2'd1,
        AS_COOL = 2'd2
    } audio_arb_state_t;

endpackage

// File: rtl/audio_dma_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after 'last', wrapping modulo NCH.
module AUDIO_rr_pick
    import AUDIO_pkg::*;
#(
    parameter int unsigned NCH = 4
) (
    input  logic [NCH-1:0]          req,
    input  logic [$clog2(NCH)-1:0]  last,
    output logic [$clog2(NCH)-1:0]  id,
    output logic                    found
);

    localparam int unsigned IW = $clog2(NCH);

    logic [IW-1:0] idx;

    always_comb begin
        id    = '0;
        found = 1'b0;
        idx   = '0;
        // Offsets 1..NCH so that 'last' itself is considered only after everyone else.
        for (int i = 1; i <= int'(NCH); i++) begin
            idx = IW'((32'(last) + 32'(i)) % NCH);
            if (!found && req[idx]) begin
                found = 1'b1;
                id    = idx;
            end
        end
    end

endmodule

// File: rtl/audio_dma_arbiter.sv
// Round-robin arbiter sharing one 32-bit bus read port between NCH audio channels.
// Optional bus-stall timeout is enabled by defining AUDIO_DMA_ARB_TIMEOUT_EN.
module audio_dma_arbiter
    import AUDIO_pkg::*;
#(
    parameter int unsigned NCH            = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    i_reset,
    input  logic                    i_clock,
    input  logic [NCH-1:0]          i_ch_request,
    input  logic [NCH*32-1:0]       i_ch_address,
    output logic [NCH-1:0]          o_ch_ready,
    output logic [31:0]             o_ch_rdata,
    output logic                    o_bus_request,
    output logic [31:0]             o_bus_address,
    input  logic                    i_bus_ready,
    input  logic [31:0]             i_bus_rdata,
    output logic [$clog2(NCH)-1:0]  o_grant_id,
    output logic                    o_active,
    output logic                    o_timeout
);

    localparam int unsigned IW = $clog2(NCH);

    audio_arb_state_t state;
    logic [IW-1:0]    last;
    logic [IW-1:0]    pick_id;
    logic             pick_found;
    logic [31:0]      pick_addr;
    logic [NCH-1:0]   grant_onehot;

    AUDIO_rr_pick #(
        .NCH (NCH)
    ) u_pick (
        .req   (i_ch_request),
        .last  (last),
        .id    (pick_id),
        .found (pick_found)
    );

    assign pick_addr    = i_ch_address[32*pick_id +: 32];
    assign grant_onehot = NCH'(1) << o_grant_id;

`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`else
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state         <= AS_IDLE;
            last          <= IW'(NCH - 1);
            o_ch_ready    <= '0;
            o_ch_rdata    <= '0;
            o_bus_request <= 1'b0;
            o_bus_address <= '0;
            o_grant_id    <= '0;
            o_active      <= 1'b0;
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
            tmo_cnt       <= '0;
            o_timeout     <= 1'b0;
`endif
        end else begin
            o_ch_ready <= '0;
            unique case (state)
                AS_IDLE: begin
                    if (pick_found) begin
                        o_grant_id    <= pick_id;
                        o_bus_address <= pick_addr;
                        o_bus_request <= 1'b1;
                        o_active      <= 1'b1;
                        state         <= AS_BUS;
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
                        tmo_cnt       <= '0;
`endif
                    end
                end
                AS_BUS: begin
                    // Bus completion takes priority over a simultaneous timeout expiry.
                    if (i_bus_ready) begin
                        o_ch_rdata    <= i_bus_rdata;
                        o_ch_ready    <= grant_onehot;
                        o_bus_request <= 1'b0;
                        last          <= o_grant_id;
                        state         <= AS_COOL;
                    end
`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        o_ch_rdata    <= '0;
                        o_ch_ready    <= grant_onehot;
                        o_bus_request <= 1'b0;
                        o_timeout     <= 1'b1;
                        last          <= o_grant_id;
                        state         <= AS_COOL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
`endif
                end
                AS_COOL: begin
                    // The served channel still holds its request this cycle; ignore all.
                    o_active <= 1'b0;
                    state    <= AS_IDLE;
                end
                default: begin
                    state <= AS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dma_arbiter.sv
// Directed self-checking bench for audio_dma_arbiter (NCH=4, TIMEOUT_CYCLES=16).
module tb_audio_dma_arbiter;

    localparam int unsigned NCH = 4;
    localparam int unsigned TMO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [NCH*32-1:0] ch_address;
    logic [NCH-1:0]    ch_ready;
    logic [31:0]       ch_rdata;
    logic              bus_request;
    logic [31:0]       bus_address;
    logic              bus_ready;
    logic [31:0]       bus_rdata;
    logic [1:0]        grant_id;
    logic              active;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign ch_address = {32'h0000_030C, 32'h0000_1000, 32'h0000_0204, 32'h0000_0100};

    audio_dma_arbiter #(
        .NCH            (NCH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_reset       (rst),
        .i_clock       (clk),
        .i_ch_request  (req),
        .i_ch_address  (ch_address),
        .o_ch_ready    (ch_ready),
        .o_ch_rdata    (ch_rdata),
        .o_bus_request (bus_request),
        .o_bus_address (bus_address),
        .i_bus_ready   (bus_ready),
        .i_bus_rdata   (bus_rdata),
        .o_grant_id    (grant_id),
        .o_active      (active),
        .o_timeout     (timeout)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        br;
        logic [31:0] bd;
        logic        e_breq;
        logic [1:0]  e_gid;
        logic [3:0]  e_rdy;
        logic        e_act;
        logic [31:0] e_rdata;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs[27];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Drive inputs between edges, then sample just after the next rising edge.
    task automatic drive(input logic r, input logic [3:0] rq, input logic br,
                         input logic [31:0] bd);
        @(negedge clk);
        rst       = r;
        req       = rq;
        bus_ready = br;
        bus_rdata = bd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '0; bus_ready = 1'b0; bus_rdata = '0;

        // Single channel with withdrawal mid-transaction, then reset and full rotation.
        vecs[0]  = '{1, 4'h0, 0, 32'h0,        0, 2'd0, 4'h0, 0, 32'h0,        32'h0};
        vecs[1]  = '{0, 4'h0, 0, 32'h0,        0, 2'd0, 4'h0, 0, 32'h0,        32'h0};
        vecs[2]  = '{0, 4'h4, 0, 32'h0,        1, 2'd2, 4'h0, 1, 32'h0,        32'h1000};
        vecs[3]  = '{0, 4'h4, 0, 32'h0,        1, 2'd2, 4'h0, 1, 32'h0,        32'h1000};
        vecs[4]  = '{0, 4'h0, 0, 32'h0,        1, 2'd2, 4'h0, 1, 32'h0,        32'h1000};
        vecs[5]  = '{0, 4'h0, 0, 32'h0,        1, 2'd2, 4'h0, 1, 32'h0,        32'h1000};
        vecs[6]  = '{0, 4'h0, 0, 32'h0,        1, 2'd2, 4'h0, 1, 32'h0,        32'h1000};
        vecs[7]  = '{0, 4'h0, 1, 32'hDEADBEEF, 0, 2'd2, 4'h4, 1, 32'hDEADBEEF, 32'h1000};
        vecs[8]  = '{0, 4'h0, 0, 32'h0,        0, 2'd2, 4'h0, 0, 32'hDEADBEEF, 32'h1000};
        vecs[9]  = '{0, 4'h0, 0, 32'h0,        0, 2'd2, 4'h0, 0, 32'hDEADBEEF, 32'h1000};
        vecs[10] = '{1, 4'hF, 0, 32'h0,        0, 2'd0, 4'h0, 0, 32'h0,        32'h0};
        vecs[11] = '{0, 4'hF, 0, 32'h0,        1, 2'd0, 4'h0, 1, 32'h0,        32'h100};
        vecs[12] = '{0, 4'hF, 1, 32'hA0A00000, 0, 2'd0, 4'h1, 1, 32'hA0A00000, 32'h100};
        vecs[13] = '{0, 4'hF, 0, 32'h0,        0, 2'd0, 4'h0, 0, 32'hA0A00000, 32'h100};
        vecs[14] = '{0, 4'hF, 0, 32'h0,        1, 2'd1, 4'h0, 1, 32'hA0A00000, 32'h204};
        vecs[15] = '{0, 4'hF, 1, 32'hB1B10001, 0, 2'd1, 4'h2, 1, 32'hB1B10001, 32'h204};
        vecs[16] = '{0, 4'hF, 0, 32'h0,        0, 2'd1, 4'h0, 0, 32'hB1B10001, 32'h204};
        vecs[17] = '{0, 4'hF, 0, 32'h0,        1, 2'd2, 4'h0, 1, 32'hB1B10001, 32'h1000};
        vecs[18] = '{0, 4'hF, 1, 32'hC2C20002, 0, 2'd2, 4'h4, 1, 32'hC2C20002, 32'h1000};
        vecs[19] = '{0, 4'hF, 0, 32'h0,        0, 2'd2, 4'h0, 0, 32'hC2C20002, 32'h1000};
        vecs[20] = '{0, 4'hF, 0, 32'h0,        1, 2'd3, 4'h0, 1, 32'hC2C20002, 32'h30C};
        vecs[21] = '{0, 4'hF, 1, 32'hD3D30003, 0, 2'd3, 4'h8, 1, 32'hD3D30003, 32'h30C};
        vecs[22] = '{0, 4'hF, 0, 32'h0,        0, 2'd3, 4'h0, 0, 32'hD3D30003, 32'h30C};
        vecs[23] = '{0, 4'hF, 0, 32'h0,        1, 2'd0, 4'h0, 1, 32'hD3D30003, 32'h100};
        vecs[24] = '{0, 4'hF, 1, 32'hE0E00004, 0, 2'd0, 4'h1, 1, 32'hE0E00004, 32'h100};
        vecs[25] = '{0, 4'hF, 0, 32'h0,        0, 2'd0, 4'h0, 0, 32'hE0E00004, 32'h100};
        vecs[26] = '{0, 4'hF, 0, 32'h0,        1, 2'd1, 4'h0, 1, 32'hE0E00004, 32'h204};

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].br, vecs[i].bd);
            chk($sformatf("vec%0d bus_request", i), 32'(bus_request), 32'(vecs[i].e_breq));
            chk($sformatf("vec%0d grant_id", i), 32'(grant_id), 32'(vecs[i].e_gid));
            chk($sformatf("vec%0d ch_ready", i), 32'(ch_ready), 32'(vecs[i].e_rdy));
            chk($sformatf("vec%0d active", i), 32'(active), 32'(vecs[i].e_act));
            chk($sformatf("vec%0d ch_rdata", i), ch_rdata, vecs[i].e_rdata);
            chk($sformatf("vec%0d bus_address", i), bus_address, vecs[i].e_addr);
            chk($sformatf("vec%0d timeout", i), 32'(timeout), 32'h0);
        end

        // Same-channel re-request: channel 1 is in flight and keeps requesting.
        drive(0, 4'h2, 1, 32'h11111111);
        chk("rereq pulse", 32'(ch_ready), 32'h2);
        chk("rereq rdata", ch_rdata, 32'h11111111);
        drive(0, 4'h2, 0, 32'h0);
        chk("rereq cool no grant", 32'(bus_request), 32'h0);
        chk("rereq cool inactive", 32'(active), 32'h0);
        chk("rereq cool rdata held", ch_rdata, 32'h11111111);
        drive(0, 4'h2, 0, 32'h0);
        chk("rereq regrant", 32'(bus_request), 32'h1);
        chk("rereq regrant id", 32'(grant_id), 32'h1);
        drive(0, 4'h2, 1, 32'h22222222);
        chk("rereq second pulse", 32'(ch_ready), 32'h2);
        drive(0, 4'h0, 0, 32'h0);

        // Reset while channel 3 is on the bus; channel 0 also waiting.
        drive(0, 4'h9, 0, 32'h0);
        chk("rst grant id", 32'(grant_id), 32'h3);
        chk("rst grant addr", bus_address, 32'h30C);
        drive(0, 4'h9, 0, 32'h0);
        chk("rst bus held", 32'(bus_request), 32'h1);
        drive(1, 4'h9, 0, 32'h0);
        chk("rst drops request", 32'(bus_request), 32'h0);
        chk("rst no pulse", 32'(ch_ready), 32'h0);
        chk("rst inactive", 32'(active), 32'h0);
        chk("rst clears rdata", ch_rdata, 32'h0);
        drive(0, 4'h9, 0, 32'h0);
        chk("post rst grant id", 32'(grant_id), 32'h0);
        chk("post rst grant req", 32'(bus_request), 32'h1);
        chk("post rst grant addr", bus_address, 32'h100);
        drive(0, 4'h9, 1, 32'h33333333);
        chk("post rst pulse", 32'(ch_ready), 32'h1);
        drive(0, 4'h0, 0, 32'h0);

`ifdef AUDIO_DMA_ARB_TIMEOUT_EN
        // Bus never answers channel 2: silence after TMO cycles, flag sticks.
        drive(0, 4'h4, 0, 32'h0);
        chk("tmo grant id", 32'(grant_id), 32'h2);
        for (int i = 1; i < int'(TMO); i++) begin
            drive(0, 4'h0, 0, 32'h0);
            chk($sformatf("tmo wait%0d ready", i), 32'(ch_ready), 32'h0);
            chk($sformatf("tmo wait%0d busreq", i), 32'(bus_request), 32'h1);
        end
        drive(0, 4'h0, 0, 32'h0);
        chk("tmo pulse", 32'(ch_ready), 32'h4);
        chk("tmo rdata zero", ch_rdata, 32'h0);
        chk("tmo flag", 32'(timeout), 32'h1);
        chk("tmo busreq drop", 32'(bus_request), 32'h0);
        drive(0, 4'h8, 0, 32'h0);
        chk("tmo cool ignore", 32'(bus_request), 32'h0);
        drive(0, 4'h8, 0, 32'h0);
        chk("tmo next grant", 32'(grant_id), 32'h3);
        drive(0, 4'h8, 1, 32'h44444444);
        chk("tmo next pulse", 32'(ch_ready), 32'h8);
        chk("tmo next rdata", ch_rdata, 32'h44444444);
        chk("tmo flag sticky", 32'(timeout), 32'h1);
        drive(0, 4'h0, 0, 32'h0);

        // Bus ready lands exactly in the expiry cycle: bus data wins.
        drive(1, 4'h0, 0, 32'h0);
        chk("tmo flag reset", 32'(timeout), 32'h0);
        drive(0, 4'h1, 0, 32'h0);
        chk("exp grant id", 32'(grant_id), 32'h0);
        for (int i = 1; i < int'(TMO); i++) begin
            drive(0, 4'h1, 0, 32'h0);
            chk($sformatf("exp wait%0d ready", i), 32'(ch_ready), 32'h0);
        end
        drive(0, 4'h1, 1, 32'h12345678);
        chk("exp pulse", 32'(ch_ready), 32'h1);
        chk("exp rdata", ch_rdata, 32'h12345678);
        chk("exp no flag", 32'(timeout), 32'h0);
        drive(0, 4'h0, 0, 32'h0);
`else
        // Without the timeout feature a stalled bus just waits.
        drive(0, 4'h4, 0, 32'h0);
        chk("stall grant id", 32'(grant_id), 32'h2);
        for (int i = 0; i < 40; i++) begin
            drive(0, 4'h4, 0, 32'h0);
            chk($sformatf("stall%0d busreq", i), 32'(bus_request), 32'h1);
            chk($sformatf("stall%0d ready", i), 32'(ch_ready), 32'h0);
            chk($sformatf("stall%0d timeout", i), 32'(timeout), 32'h0);
        end
        drive(0, 4'h4, 1, 32'h55555555);
        chk("stall pulse", 32'(ch_ready), 32'h4);
        chk("stall rdata", ch_rdata, 32'h55555555);
        drive(0, 4'h0, 0, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_dma_arbiter.md
# audio_dma_arbiter

Round-robin arbiter that shares one 32-bit DMA bus master port between `NCH` audio channels. Each channel uses a single-word request/ready read protocol: it holds a request with an address until it sees ready, then samples read data one cycle later. The arbiter sits between the channel instances and the system bus master. It serialises their word reads, returns data to the granted channel only, and holds that data stable long enough for the channel's enqueue state to capture it.

## Interface
Parameters:
- `NCH`, 4: number of channels, 2..8.
- `TIMEOUT_CYCLES`, 1024: bus-stall limit in cycles. Used only with `AUDIO_DMA_ARB_TIMEOUT_EN`.

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- `i_reset` in 1: synchronous, active-high reset.
- `i_clock` in 1: single clock for the whole block.
- `i_ch_request` in `NCH`: per-channel read request; a level signal, held until that channel's ready.
- `i_ch_address` in `NCH*32`: per-channel word address; channel k occupies bits `[32k+31:32k]`.
- `o_ch_ready` out `NCH`: one-cycle ready pulse to the granted channel.
- `o_ch_rdata` out 32: read data, broadcast to all channels and registered.
- `o_bus_request` out 1: request to the bus master.
- `o_bus_address` out 32: bus address.
- `i_bus_ready` in 1: bus completion, one cycle.
- `i_bus_rdata` in 32: bus read data, valid while `i_bus_ready` is high.
- `o_grant_id` out `$clog2(NCH)`: currently or last granted channel.
- `o_active` out 1: high while a transaction is outstanding.
- `o_timeout` out 1: sticky timeout flag.

## Operation
- **Reset values.** All outputs are 0. The state is `AS_IDLE`. The round-robin pointer `last` is `NCH-1`, so channel 0 wins first.
- **`AS_IDLE`.** If any `i_ch_request` bit is set:
  - Select the first requesting channel, searching `last+1`, `last+2`, … modulo `NCH`.
  - Latch its id into `o_grant_id` and its address into `o_bus_address`.
  - Set `o_bus_request` and `o_active`, then go to `AS_BUS`.
- **`AS_BUS`.**
  - `o_bus_request` stays high and `o_bus_address` stays stable.
  - On `i_bus_ready`:
    - Capture `i_bus_rdata` into `o_ch_rdata`.
    - Pulse `o_ch_ready[grant]`.
    - Clear `o_bus_request`.
    - Set `last` to `grant`.
    - Go to `AS_COOL`.
- **`AS_COOL`.**
  - This state lasts exactly one cycle. During it all requests are ignored, because the served channel's request is still high for one more cycle.
  - Clear `o_active` and return to `AS_IDLE`.
- **Request withdrawal.** A channel dropping its request while granted has no effect; the transaction completes normally.
- **New requests during a transaction.** Requests from other channels while busy simply wait; they are level signals, so they are not latched.
- **Data hold.** `o_ch_rdata` holds its value until the next capture. It is never cleared between transactions.
- **Reset mid-transaction.** Reset drops `o_bus_request` on the same edge without completing the transaction. No ready pulse is issued, and the state returns to `AS_IDLE`.

## Timing
- Grant latency: request seen in `AS_IDLE` at edge n gives `o_bus_request` = 1 after edge n.
- Ready pulse and `o_ch_rdata` update on the edge after the cycle where `i_bus_ready` = 1.
- `o_ch_rdata` is stable for at least 2 cycles after the ready pulse. This covers the channel's one-cycle-late sample.
- Minimum period per word: 3 cycles plus bus latency (`AS_IDLE` → `AS_BUS` → `AS_COOL`).
- Fairness: with all channels requesting continuously, grants rotate 0,1,…,`NCH-1`, 0, … with no channel skipped.

## Configuration
- **With `AUDIO_DMA_ARB_TIMEOUT_EN` defined:**
  - A 16-bit counter clears on entry to `AS_BUS` and increments each cycle in `AS_BUS`.
  - When the counter reaches `TIMEOUT_CYCLES-1` with no `i_bus_ready`:
    - Drop `o_bus_request`.
    - Load `o_ch_rdata` with 0 and pulse `o_ch_ready[grant]`, so the channel plays silence rather than hanging.
    - Set `o_timeout`, which stays set until reset.
    - Go to `AS_COOL`.
  - If `i_bus_ready` and expiry occur in the same cycle, ready wins and the bus data is used.
- **Without the macro:** `AS_BUS` waits indefinitely, there is no counter, and `o_timeout` is tied to 0.

## Structure
- **Shared package (`AUDIO_pkg`):**
  - `audio_arb_state_t`, a 2-bit enum with `AS_IDLE`, `AS_BUS`, `AS_COOL`.
  - `AUDIO_ARB_MAX_CH` = 8.
- **Sub-module `AUDIO_rr_pick`:** combinational round-robin selector with inputs (request vector, `last`) and outputs (`id`, `found`).
- The top module contains the state machine, address/data registers and the optional timeout counter.

## Test plan
- **Single channel.** `NCH`=4, channel 2 requests address 0x1000, bus ready after 5 cycles with data 0xDEADBEEF → `o_ch_ready` = 4'b0100 for one cycle, `o_ch_rdata` = 0xDEADBEEF, and the data is held for at least 2 cycles.
- **Rotation.** All 4 channels request continuously, bus ready after 1 cycle → grant order 0,1,2,3,0,1, and each grant occurs 3 cycles after the previous one.
- **Same-channel re-request.** Channel 1 re-requests immediately after its ready pulse → channel 1 is not re-granted during `AS_COOL`, and its next grant is no earlier than 2 cycles after the pulse.
- **Reset mid-transaction.** Assert `i_reset` in `AS_BUS` while channel 3 is waiting → the next cycle shows `o_bus_request` = 0 and no ready pulse; after reset, channel 0 (also requesting) is granted first.
- **Timeout.** With `AUDIO_DMA_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, the bus never responds → a ready pulse arrives 16 cycles after the grant with `o_ch_rdata` = 0, `o_timeout` = 1, and the next channel is served normally.
- **Ready at expiry.** With `AUDIO_DMA_ARB_TIMEOUT_EN`, `i_bus_ready` arrives in the expiry cycle with data 0x12345678 → `o_ch_rdata` = 0x12345678 and `o_timeout` stays 0.
